mem_read_responder: RTL and testbench

Responder end of the CPU's memory-access request interface. It accepts a read request (enable strobe, 3-bit access control, 48-bit address) from the MEM stage and performs the access as a sequence of byte reads on a fixed-latency, byte-wide memory port. It assembles the bytes little-endian into a zero- or sign-extended 48-bit result, then returns it with a one-cycle HANDSHAKE pulse. BUSY is held while the access is in flight so the pipeline can gate its clock or stall.

---
 rtl/mem_read_responder.sv | 185 ++++++++++++++++++
 tb/tb_mem_read_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// mem_read_responder
// Responder end of the CPU memory-access request interface. A read request
// (byte/half/word, signed or unsigned) is performed as a series of single-byte
// reads on a fixed-latency byte-wide memory port. The bytes are assembled
// little-endian, extended to 48 bits and returned with a one-cycle HANDSHAKE.
//
// Optional feature macro: MEM_RESP_ALIGN_CHECK_EN
//   defined   -> half/word requests with ADDRESS[0]=1 are rejected with ERROR
//   undefined -> misaligned half/word requests are read byte by byte as usual

module mem_read_responder #(
    parameter int DATA_W  = 48,
    parameter int MEM_AW  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [2:0]        ctrl_i,
    input  logic [DATA_W-1:0] address_i,
    output logic [DATA_W-1:0] read_o,
    output logic              handshake_o,
    output logic              error_o,
    output logic              busy_o,
    output logic              mem_re_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [MEM_AW-1:0] addr_q;
    logic [2:0]        ctrl_q;
    logic [2:0]        byteIdx_q;
    logic [LAT_W-1:0]  latCnt_q;
    logic [DATA_W-1:0] assemble_q;
    logic [DATA_W-1:0] read_q;
    logic              handshake_q;
    logic              error_q;
    logic              busy_q;
    logic              memRe_q;
    logic [MEM_AW-1:0] memAddr_q;

    logic              reqLegal;
    logic [2:0]        byteCount;
    logic              lastByte;
    logic              latDone;
    logic [DATA_W-1:0] assemble_d;
    logic [DATA_W-1:0] extended_d;
    logic [MEM_AW-1:0] nextAddr_d;
    logic              unusedAddrBits;

    // Only the low MEM_AW address bits reach the byte memory.
    assign unusedAddrBits = ^address_i[DATA_W-1:MEM_AW];

    // Request decode: legal access types, and optionally reject misaligned half/word reads.
    always_comb begin
        reqLegal = (ctrl_i <= 3'b100);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if ((ctrl_i[2] | ctrl_i[1]) && address_i[0]) begin
            reqLegal = 1'b0;
        end
`endif
    end

    // Datapath helpers: byte count, merge of the arriving byte, extension and next byte address.
    always_comb begin
        case (ctrl_q)
            3'b000, 3'b001: byteCount = 3'd1;
            3'b010, 3'b011: byteCount = 3'd2;
            default:        byteCount = 3'd6;
        endcase

        lastByte = (3'(byteIdx_q + 3'd1) == byteCount);
        latDone  = (latCnt_q == LAT_W'(MEM_LAT - 1));

        assemble_d = assemble_q;
        for (int b = 0; b < BYTES; b++) begin
            if (byteIdx_q == 3'(b)) begin
                assemble_d[8*b +: 8] = mem_rdata_i;
            end
        end

        case (ctrl_q)
            3'b000:  extended_d = {{(DATA_W-8){1'b0}}, assemble_d[7:0]};
            3'b001:  extended_d = {{(DATA_W-8){assemble_d[7]}}, assemble_d[7:0]};
            3'b010:  extended_d = {{(DATA_W-16){1'b0}}, assemble_d[15:0]};
            3'b011:  extended_d = {{(DATA_W-16){assemble_d[15]}}, assemble_d[15:0]};
            default: extended_d = assemble_d;
        endcase

        nextAddr_d = addr_q + MEM_AW'(byteIdx_q) + MEM_AW'(1);
    end

    // Main FSM: request acceptance, issue/wait loop per byte, and the completion cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ctrl_q      <= '0;
            byteIdx_q   <= '0;
            latCnt_q    <= '0;
            assemble_q  <= '0;
            read_q      <= '0;
            handshake_q <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            memRe_q     <= 1'b0;
            memAddr_q   <= '0;
        end else begin
            handshake_q <= 1'b0;
            error_q     <= 1'b0;
            memRe_q     <= 1'b0;
            memAddr_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        addr_q     <= address_i[MEM_AW-1:0];
                        ctrl_q     <= ctrl_i;
                        byteIdx_q  <= '0;
                        assemble_q <= '0;
                        busy_q     <= 1'b1;
                        if (reqLegal) begin
                            state_q   <= S_ISSUE;
                            memRe_q   <= 1'b1;
                            memAddr_q <= address_i[MEM_AW-1:0];
                        end else begin
                            state_q     <= S_DONE;
                            handshake_q <= 1'b1;
                            error_q     <= 1'b1;
                            read_q      <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_WAIT;
                    latCnt_q <= '0;
                end
                S_WAIT: begin
                    if (latDone) begin
                        assemble_q <= assemble_d;
                        byteIdx_q  <= 3'(byteIdx_q + 3'd1);
                        latCnt_q   <= '0;
                        if (lastByte) begin
                            state_q     <= S_DONE;
                            handshake_q <= 1'b1;
                            read_q      <= extended_d;
                        end else begin
                            state_q   <= S_ISSUE;
                            memRe_q   <= 1'b1;
                            memAddr_q <= nextAddr_d;
                        end
                    end else begin
                        latCnt_q <= LAT_W'(latCnt_q + LAT_W'(1));
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign read_o      = read_q;
    assign handshake_o = handshake_q;
    assign error_o     = error_q;
    assign busy_o      = busy_q;
    assign mem_re_o    = memRe_q;
    assign mem_addr_o  = memAddr_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Testbench for mem_read_responder: directed cases plus randomized requests,
// with a scoreboard fed by the stimulus and drained by a monitor process.
module tb_mem_read_responder;

    localparam int DATA_W  = 48;
    localparam int MEM_AW  = 16;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic [47:0] read;
        logic        err;
        int          cyc;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic [2:0]        ctrl_i;
    logic [DATA_W-1:0] address_i;
    logic [DATA_W-1:0] read_o;
    logic              handshake_o;
    logic              error_o;
    logic              busy_o;
    logic              mem_re_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [7:0]        mem_rdata_i;

    logic [7:0]  memArr [65536];
    logic        pipeValid [MEM_LAT];
    logic [15:0] pipeAddr [MEM_LAT];
    logic [7:0]  junkByte;

    exp_t        resQ [$];
    logic [15:0] addrQ [$];
    logic [47:0] lastRead;
    int          cycleCnt;
    int          busyStart;
    int          busyEnd;
    bit          monitorOn;
    int          vectors;
    int          miscompares;

    mem_read_responder #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .ctrl_i     (ctrl_i),
        .address_i  (address_i),
        .read_o     (read_o),
        .handshake_o(handshake_o),
        .error_o    (error_o),
        .busy_o     (busy_o),
        .mem_re_o   (mem_re_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Cycle counter and a fixed-latency byte memory; garbage is driven whenever no read is due.
    always @(posedge clk_i) begin
        cycleCnt     <= cycleCnt + 1;
        junkByte     <= 8'($urandom);
        pipeValid[0] <= mem_re_o;
        pipeAddr[0]  <= mem_addr_o;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeAddr[i]  <= pipeAddr[i-1];
        end
    end

    assign mem_rdata_i = (pipeValid[MEM_LAT-1] === 1'b1) ? memArr[pipeAddr[MEM_LAT-1]] : junkByte;

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference model: little-endian gather of n bytes with 16-bit address wrap, then extension.
    function automatic logic [47:0] modelRead(input logic [2:0] ctrl, input logic [15:0] a, input int n);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = v | (48'(memArr[16'(a + 16'(i))]) << (8 * i));
        end
        if (ctrl == 3'b001 && v[7])  v = v | 48'hFFFF_FFFF_FF00;
        if (ctrl == 3'b011 && v[15]) v = v | 48'hFFFF_FFFF_0000;
        return v;
    endfunction

    task automatic applyStimulus(input logic [2:0] ctrl, input logic [47:0] addr, input bit holdJunk);
        int   n;
        int   dur;
        int   acc;
        bit   legal;
        exp_t e;
        @(negedge clk_i);
        enable_i  = 1'b1;
        ctrl_i    = ctrl;
        address_i = addr;
        n = (ctrl <= 3'b001) ? 1 : (ctrl <= 3'b011) ? 2 : 6;
        legal = (ctrl <= 3'b100);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if (ctrl >= 3'b010 && addr[0]) legal = 1'b0;
`endif
        @(posedge clk_i);
        #1;
        acc = cycleCnt;
        if (legal) begin
            for (int i = 0; i < n; i++) addrQ.push_back(16'(addr[15:0] + 16'(i)));
            dur    = 1 + n * (MEM_LAT + 1);
            e.read = modelRead(ctrl, addr[15:0], n);
            e.err  = 1'b0;
        end else begin
            dur    = 1;
            e.read = '0;
            e.err  = 1'b1;
        end
        e.cyc     = acc + dur - 1;
        resQ.push_back(e);
        busyStart = acc;
        busyEnd   = acc + dur - 1;
        for (int c = 0; c < dur; c++) begin
            @(negedge clk_i);
            if (holdJunk) begin
                enable_i  = 1'($urandom);
                ctrl_i    = 3'($urandom);
                address_i = {16'($urandom), 32'($urandom)};
            end else begin
                enable_i = 1'b0;
            end
        end
    endtask

    // Monitor: pops expected memory addresses and results as the DUT presents them.
    always @(negedge clk_i) begin
        if (monitorOn) begin
            checkOutput("busy", 48'(busy_o), 48'(cycleCnt >= busyStart && cycleCnt <= busyEnd));
            if (mem_re_o) begin
                if (addrQ.size() == 0) begin
                    checkOutput("stray mem_re", 48'(mem_re_o), 48'd0);
                end else begin
                    checkOutput("mem_addr", 48'(mem_addr_o), 48'(addrQ.pop_front()));
                end
            end else begin
                checkOutput("mem_addr idle", 48'(mem_addr_o), 48'd0);
            end
            if (handshake_o) begin
                if (resQ.size() == 0) begin
                    checkOutput("stray handshake", 48'(handshake_o), 48'd0);
                end else begin
                    exp_t e;
                    e = resQ.pop_front();
                    checkOutput("read", read_o, e.read);
                    checkOutput("error", 48'(error_o), 48'(e.err));
                    checkOutput("handshake cycle", 48'(cycleCnt), 48'(e.cyc));
                    checkOutput("bytes outstanding", 48'(addrQ.size()), 48'd0);
                    lastRead = e.read;
                end
            end else begin
                checkOutput("read hold", read_o, lastRead);
                checkOutput("error idle", 48'(error_o), 48'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        vectors     = 0;
        miscompares = 0;
        cycleCnt    = 0;
        busyStart   = 1;
        busyEnd     = 0;
        lastRead    = '0;
        monitorOn   = 1'b0;
        reset_i     = 1'b1;
        enable_i    = 1'b0;
        ctrl_i      = '0;
        address_i   = '0;
        for (int i = 0; i < 65536; i++) memArr[i] = 8'($urandom);

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        checkOutput("reset read", read_o, 48'd0);
        checkOutput("reset handshake", 48'(handshake_o), 48'd0);
        checkOutput("reset error", 48'(error_o), 48'd0);
        checkOutput("reset busy", 48'(busy_o), 48'd0);
        checkOutput("reset mem_re", 48'(mem_re_o), 48'd0);
        checkOutput("reset mem_addr", 48'(mem_addr_o), 48'd0);
        monitorOn = 1'b1;

        // Directed cases.
        memArr[16'h0010] = 8'hF3;
        applyStimulus(3'b000, 48'h0000_0000_0010, 1'b0);
        memArr[16'h0020] = 8'h34;
        memArr[16'h0021] = 8'h92;
        applyStimulus(3'b011, 48'h0000_0000_0020, 1'b0);
        memArr[16'hFFFE] = 8'h01;
        memArr[16'hFFFF] = 8'h02;
        memArr[16'h0000] = 8'h03;
        memArr[16'h0001] = 8'h04;
        memArr[16'h0002] = 8'h05;
        memArr[16'h0003] = 8'h06;
        applyStimulus(3'b100, 48'hABCD_0000_FFFE, 1'b0);
        applyStimulus(3'b110, 48'h0000_0000_0040, 1'b0);
        memArr[16'h0022] = 8'h7E;
        applyStimulus(3'b010, 48'h0000_0000_0021, 1'b0);
        applyStimulus(3'b001, 48'h0000_0000_0010, 1'b1);

        // Randomized requests with junk on the request side while busy.
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  c;
            logic [47:0] a;
            c = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFF8 | 16'($urandom_range(0, 7));
            applyStimulus(c, a, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk_i);
                enable_i = 1'b0;
            end
        end

        // Reset in cycle 5 of a word read while ENABLE stays high.
        @(negedge clk_i);
        enable_i  = 1'b1;
        ctrl_i    = 3'b100;
        address_i = 48'h0000_0000_1230;
        @(posedge clk_i);
        #1;
        acc = cycleCnt;
        for (int i = 0; i < 6; i++) addrQ.push_back(16'(16'h1230 + 16'(i)));
        busyStart = acc;
        busyEnd   = acc + 18;
        repeat (4) begin
            @(negedge clk_i);
            enable_i = 1'b1;
            ctrl_i   = 3'b000;
        end
        @(negedge clk_i);
        reset_i  = 1'b1;
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        busyEnd  = cycleCnt - 1;
        lastRead = '0;
        addrQ.delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        checkOutput("abort handshake", 48'(handshake_o), 48'd0);
        checkOutput("abort busy", 48'(busy_o), 48'd0);
        checkOutput("abort read", read_o, 48'd0);
        checkOutput("abort mem_re", 48'(mem_re_o), 48'd0);
        repeat (25) @(negedge clk_i);

        checkOutput("pending results", 48'(resQ.size()), 48'd0);
        checkOutput("pending addresses", 48'(addrQ.size()), 48'd0);
        monitorOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
